// File: rtl/ip_arp_arb_pkg.sv
// Shared types and widths for the ARP request arbiter (ip_arp_req_arb).
package ip_arp_arb_pkg;

  localparam int unsigned IP_W    = 32;
  localparam int unsigned MAC_W   = 48;
  localparam int unsigned GRANT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ip_arp_arb_sel.sv
// Combinational requester selector: fixed priority from index 0, or
// round-robin scan starting at the pointer. Emits one-hot grant and its index.
module ip_arp_arb_sel
  import ip_arp_arb_pkg::*;
#(
  parameter int unsigned PORTS       = 4,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic [PORTS-1:0]   req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [PORTS-1:0]   gnt,
  output logic [GRANT_W-1:0] idx,
  output logic               found
);

  logic [2*PORTS-1:0] dbl;
  int unsigned        start;
  int unsigned        cand;

  always_comb begin
    start = '0;
    if (ROUND_ROBIN != 0) start = 32'(ptr);
    // Doubled vector shifted by the start point: bit k is requester (start+k) mod PORTS.
    dbl   = {req, req} >> start;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        cand  = start + k;
        if (cand >= PORTS) cand = cand - PORTS;
      end
    end
    idx = GRANT_W'(cand);
    gnt = found ? (PORTS'(1) << cand) : '0;
  end

endmodule

// File: rtl/ip_arp_req_arb.sv
// Arbitrates PORTS requesters onto one ARP resolver channel, holding the grant
// until the response returns. Optional watchdog: define IP_ARP_ARB_TIMEOUT_EN.
module ip_arp_req_arb
  import ip_arp_arb_pkg::*;
#(
  parameter int unsigned PORTS       = 4,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned TIMEOUT     = 125000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORTS-1:0]      s_arp_request_valid,
  output logic [PORTS-1:0]      s_arp_request_ready,
  input  logic [PORTS*IP_W-1:0] s_arp_request_ip,
  output logic [PORTS-1:0]      s_arp_response_valid,
  input  logic [PORTS-1:0]      s_arp_response_ready,
  output logic                  s_arp_response_error,
  output logic [MAC_W-1:0]      s_arp_response_mac,
  output logic                  m_arp_request_valid,
  input  logic                  m_arp_request_ready,
  output logic [IP_W-1:0]       m_arp_request_ip,
  input  logic                  m_arp_response_valid,
  output logic                  m_arp_response_ready,
  input  logic                  m_arp_response_error,
  input  logic [MAC_W-1:0]      m_arp_response_mac,
  output logic                  busy,
  output logic [GRANT_W-1:0]    grant_index
);

  if (PORTS < 1 || PORTS > 16 || TIMEOUT < 2) begin : g_cfg_err
    $error("ip_arp_req_arb: unsupported PORTS/TIMEOUT");
  end

  arb_state_e         state_q, state_d;
  logic [IP_W-1:0]    ip_q, ip_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_q, rr_d;
  logic               err_q, err_d;
  logic [MAC_W-1:0]   mac_q, mac_d;
`ifdef IP_ARP_ARB_TIMEOUT_EN
  logic [31:0]        cnt_q, cnt_d;
`endif

  logic [PORTS-1:0]   sel_gnt;
  logic [GRANT_W-1:0] sel_idx;
  logic               sel_found;
  logic [PORTS-1:0]   grant_oh;

  ip_arp_arb_sel #(
    .PORTS      (PORTS),
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_sel (
    .req  (s_arp_request_valid),
    .ptr  (rr_q),
    .gnt  (sel_gnt),
    .idx  (sel_idx),
    .found(sel_found)
  );

  always_comb begin
    state_d  = state_q;
    ip_d     = ip_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    err_d    = err_q;
    mac_d    = mac_q;
`ifdef IP_ARP_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    grant_oh = PORTS'(1) << grant_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          for (int unsigned i = 0; i < PORTS; i++) begin
            if (sel_gnt[i]) ip_d = s_arp_request_ip[IP_W*i +: IP_W];
          end
          grant_d = sel_idx;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_arp_request_ready) begin
          state_d = ST_WAIT;
`ifdef IP_ARP_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (m_arp_response_valid) begin
          err_d   = m_arp_response_error;
          mac_d   = m_arp_response_mac;
          state_d = ST_RESP;
        end
`ifdef IP_ARP_ARB_TIMEOUT_EN
        else if (cnt_q == 32'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          mac_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
`endif
      end
      ST_RESP: begin
        if (|(s_arp_response_ready & grant_oh)) begin
          state_d = ST_IDLE;
          rr_d    = (32'(grant_q) == PORTS - 1) ? '0 : grant_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready outputs are gated by rst_n so they read zero while reset is held.
  always_comb begin
    s_arp_request_ready  = (rst_n && state_q == ST_IDLE) ? sel_gnt : '0;
    m_arp_response_ready = rst_n && (state_q == ST_IDLE || state_q == ST_WAIT);
    s_arp_response_valid = (state_q == ST_RESP) ? grant_oh : '0;
    m_arp_request_valid  = (state_q == ST_REQ);
    m_arp_request_ip     = ip_q;
    s_arp_response_error = err_q;
    s_arp_response_mac   = mac_q;
    busy                 = (state_q != ST_IDLE);
    grant_index          = grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ip_q    <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      mac_q   <= '0;
`ifdef IP_ARP_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      mac_q   <= mac_d;
`ifdef IP_ARP_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule
